axi4_s_read_responder: RTL

// AXI4 slave-side read responder: accepts AR requests, walks the burst addresses
// (FIXED/INCR/WRAP) and fetches each beat from a simple synchronous memory read port.

---
 rtl/axi4_s_read_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_s_read_responder.sv
// axi4_s_read_responder
// AXI4 slave read responder. It accepts one AR request at a time and walks the
// burst addresses (FIXED, INCR or WRAP). For each beat it issues one read on a
// synchronous memory port. It then returns the data as an R beat with rid,
// rresp and rlast.
//
// Ports
//   aclk, reset           clock and synchronous active-high reset
//   ar*                   read address channel (araddr, arburst, arid, arlen,
//                         arsize, arvalid in; arready out)
//   r*                    read data channel (rdata, rid, rresp, rlast, rvalid
//                         out; rready in)
//   mem_rd_en, mem_addr   memory read strobe and byte address
//   mem_rd_data           memory data, valid the cycle after mem_rd_en
//
// Every output comes straight from a register.
module axi4_s_read_responder #(
  parameter int A = 32,
  parameter int N = 8,
  parameter int I = 1
) (
  input  logic           aclk,
  input  logic           reset,
  input  logic [A-1:0]   araddr,
  input  logic [1:0]     arburst,
  input  logic [I-1:0]   arid,
  input  logic [7:0]     arlen,
  input  logic [2:0]     arsize,
  input  logic           arvalid,
  output logic           arready,
  output logic [8*N-1:0] rdata,
  output logic [I-1:0]   rid,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic           rvalid,
  input  logic           rready,
  output logic           mem_rd_en,
  output logic [A-1:0]   mem_addr,
  input  logic [8*N-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  localparam logic [2:0] MAX_SIZE = 3'($clog2(N));

  state_t         state_reg, state_next;
  logic [A-1:0]   addr_reg, addr_next;
  logic [1:0]     burst_reg, burst_next;
  logic [I-1:0]   id_reg, id_next;
  logic [7:0]     len_reg, len_next;
  logic [2:0]     size_reg, size_next;
  logic [7:0]     cnt_reg, cnt_next;
  logic           err_reg, err_next;
  logic           arready_reg, arready_next;
  logic [8*N-1:0] rdata_reg, rdata_next;
  logic [I-1:0]   rid_reg, rid_next;
  logic [1:0]     rresp_reg, rresp_next;
  logic           rlast_reg, rlast_next;
  logic           rvalid_reg, rvalid_next;
  logic           mem_rd_en_reg, mem_rd_en_next;
  logic [A-1:0]   mem_addr_reg, mem_addr_next;

  // Illegal requests still return arlen+1 beats, but they carry SLVERR and
  // never touch the memory.
  logic ar_err;
  always_comb begin
    ar_err = 1'b0;
    if (arsize > MAX_SIZE) ar_err = 1'b1;
    if (arburst == 2'b11) ar_err = 1'b1;
    if (arburst == 2'b10 && !(arlen == 8'd1 || arlen == 8'd3 ||
                              arlen == 8'd7 || arlen == 8'd15)) ar_err = 1'b1;
  end

  // Next beat address. The first beat may be unaligned. Every later
  // INCR/WRAP beat starts from the size-aligned address.
  logic [A-1:0] beat_bytes, wrap_len, aligned, incr_addr, addr_adv;
  always_comb begin
    beat_bytes = A'(1) << size_reg;
    wrap_len   = A'({1'b0, len_reg} + 9'd1) << size_reg;
    aligned    = addr_reg & ~(beat_bytes - A'(1));
    incr_addr  = aligned + beat_bytes;
    case (burst_reg)
      2'b00:   addr_adv = addr_reg;
      2'b10:   addr_adv = (aligned & ~(wrap_len - A'(1))) | (incr_addr & (wrap_len - A'(1)));
      default: addr_adv = incr_addr;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    burst_next     = burst_reg;
    id_next        = id_reg;
    len_next       = len_reg;
    size_next      = size_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    arready_next   = arready_reg;
    rdata_next     = rdata_reg;
    rid_next       = rid_reg;
    rresp_next     = rresp_reg;
    rlast_next     = rlast_reg;
    rvalid_next    = rvalid_reg;
    mem_rd_en_next = 1'b0;
    mem_addr_next  = mem_addr_reg;
    case (state_reg)
      IDLE: begin
        if (arready_reg && arvalid) begin
          addr_next      = araddr;
          burst_next     = arburst;
          id_next        = arid;
          len_next       = arlen;
          size_next      = arsize;
          cnt_next       = arlen;
          err_next       = ar_err;
          arready_next   = 1'b0;
          mem_rd_en_next = !ar_err;
          mem_addr_next  = araddr;
          state_next     = FETCH;
        end else begin
          // arready rises one cycle after reset releases.
          arready_next = 1'b1;
        end
      end
      FETCH: begin
        state_next = RESP;
      end
      RESP: begin
        if (!rvalid_reg) begin
          // Memory data is valid in this cycle. Capture it to form the beat.
          rvalid_next = 1'b1;
          rdata_next  = err_reg ? '0 : mem_rd_data;
          rid_next    = id_reg;
          rresp_next  = err_reg ? 2'b10 : 2'b00;
          rlast_next  = (cnt_reg == 8'd0);
        end else if (rready) begin
          rvalid_next = 1'b0;
          if (rlast_reg) begin
            arready_next = 1'b1;
            state_next   = IDLE;
          end else begin
            cnt_next       = cnt_reg - 8'd1;
            addr_next      = addr_adv;
            mem_addr_next  = addr_adv;
            mem_rd_en_next = !err_reg;
            state_next     = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      burst_reg     <= '0;
      id_reg        <= '0;
      len_reg       <= '0;
      size_reg      <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      arready_reg   <= 1'b0;
      rdata_reg     <= '0;
      rid_reg       <= '0;
      rresp_reg     <= '0;
      rlast_reg     <= 1'b0;
      rvalid_reg    <= 1'b0;
      mem_rd_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      burst_reg     <= burst_next;
      id_reg        <= id_next;
      len_reg       <= len_next;
      size_reg      <= size_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      arready_reg   <= arready_next;
      rdata_reg     <= rdata_next;
      rid_reg       <= rid_next;
      rresp_reg     <= rresp_next;
      rlast_reg     <= rlast_next;
      rvalid_reg    <= rvalid_next;
      mem_rd_en_reg <= mem_rd_en_next;
      mem_addr_reg  <= mem_addr_next;
    end
  end

  assign arready   = arready_reg;
  assign rdata     = rdata_reg;
  assign rid       = rid_reg;
  assign rresp     = rresp_reg;
  assign rlast     = rlast_reg;
  assign rvalid    = rvalid_reg;
  assign mem_rd_en = mem_rd_en_reg;
  assign mem_addr  = mem_addr_reg;

endmodule
